guess_game_ctrl: RTL and testbench

Number-guessing game controller. It debounces two push-buttons, latches a pseudo-random target digit 0–9, and steps the player's current guess. On each submit it counts the try and grades the guess against the target. It sits directly upstream of the seven-segment time-display block and drives that block's `data` (current digit) and `tries` inputs, plus status flags for LEDs.

---
 rtl/guess_game_ctrl.sv | 170 +++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// Number-guessing game: debounced inc/submit keys, 0-9 target latched from a free-running counter,
// guess stepping and grading with a try limit. Outputs are registered and feed the display block.

module guess_game_debounce #(
   parameter int CYCLES = 50000
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_key,
   output logic o_pulse
);
   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic          r_s1;
   logic          r_s2;
   logic          r_lvl;
   logic          r_lvl_d;
   logic          r_pulse;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_lvl   <= 1'b0;
         r_lvl_d <= 1'b0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= i_key;
         r_s2    <= r_s1;
         r_lvl_d <= r_lvl;
         r_pulse <= r_lvl & ~r_lvl_d;
         // Level only moves after CYCLES consecutive disagreeing samples.
         if (r_s2 == r_lvl) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(CYCLES - 1)) begin
            r_lvl <= r_s2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_pulse = r_pulse;
endmodule

module guess_game_ctrl #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int MAX_TRIES       = 9
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       key_inc,
   input  logic       key_submit,
   output logic [3:0] data,
   output logic [3:0] tries,
   output logic [1:0] result,
   output logic       win,
   output logic       lose
);
   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_WIN, S_LOSE} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_rnd;
   logic [3:0] r_target;
   logic [3:0] r_data;
   logic [3:0] r_tries;
   logic [1:0] r_result;
   logic       w_inc_p;
   logic       w_sub_p;
   logic [3:0] w_tries_inc;
   logic       w_hit;
   logic       w_out_of_tries;

   guess_game_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
      .CLK(CLK), .RST(RST), .i_key(key_inc), .o_pulse(w_inc_p)
   );

   guess_game_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_sub (
      .CLK(CLK), .RST(RST), .i_key(key_submit), .o_pulse(w_sub_p)
   );

   assign w_tries_inc    = (r_tries == 4'd9) ? 4'd9 : r_tries + 4'd1;
   assign w_hit          = (r_data == r_target);
   assign w_out_of_tries = (w_tries_inc == 4'(MAX_TRIES));

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rnd <= 4'd0;
      end else begin
         r_rnd <= (r_rnd == 4'd9) ? 4'd0 : r_rnd + 4'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_sub_p) w_state_nxt = S_PLAY;
         S_PLAY: begin
            if (w_sub_p) begin
               if (w_hit)               w_state_nxt = S_WIN;
               else if (w_out_of_tries) w_state_nxt = S_LOSE;
            end
         end
         default: if (w_sub_p) w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      win  = 1'b0;
      lose = 1'b0;
      case (r_state)
         S_WIN:   win  = 1'b1;
         S_LOSE:  lose = 1'b1;
         default: ;
      endcase
   end

   // Submit takes priority over inc and grades the pre-increment digit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_target <= 4'd0;
         r_data   <= 4'd0;
         r_tries  <= 4'd0;
         r_result <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_data   <= 4'd0;
               r_tries  <= 4'd0;
               r_result <= 2'b00;
               if (w_sub_p) r_target <= r_rnd;
            end
            S_PLAY: begin
               if (w_sub_p) begin
                  r_tries <= w_tries_inc;
                  if (w_hit)                    r_result <= 2'b11;
                  else if (r_data < r_target)   r_result <= 2'b01;
                  else                          r_result <= 2'b10;
                  if (!w_hit && w_out_of_tries) r_data <= r_target;
               end else if (w_inc_p) begin
                  r_data <= (r_data == 4'd9) ? 4'd0 : r_data + 4'd1;
               end
            end
            default: begin
               if (w_sub_p) begin
                  r_data   <= 4'd0;
                  r_tries  <= 4'd0;
                  r_result <= 2'b00;
               end
            end
         endcase
      end
   end

   assign data   = r_data;
   assign tries  = r_tries;
   assign result = r_result;
endmodule

// File: tb/tb_guess_game_ctrl.sv
// Bench for guess_game_ctrl: directed game scenarios then random key presses against a game-rule model.

module tb_guess_game_ctrl;
   localparam int DB  = 4;
   localparam int MT  = 3;
   localparam int LAT = DB + 3;
   localparam int PH_IDLE = 0, PH_PLAY = 1, PH_WIN = 2, PH_LOSE = 3;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       key_inc = 1'b0;
   logic       key_submit = 1'b0;
   logic [3:0] data;
   logic [3:0] tries;
   logic [1:0] result;
   logic       win;
   logic       lose;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int m_phase = PH_IDLE;
   int m_data = 0;
   int m_tries = 0;
   int m_result = 0;
   int m_target = 0;

   guess_game_ctrl #(.DEBOUNCE_CYCLES(DB), .MAX_TRIES(MT)) dut (
      .CLK(CLK), .RST(RST), .key_inc(key_inc), .key_submit(key_submit),
      .data(data), .tries(tries), .result(result), .win(win), .lose(lose)
   );

   always #5 CLK = ~CLK;

   // Edges since the last reset edge; equals the game's random counter modulo 10.
   always @(posedge CLK) begin
      if (RST) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      @(negedge CLK);
      check({tag, "_data"},   32'(data),   32'(m_data));
      check({tag, "_tries"},  32'(tries),  32'(m_tries));
      check({tag, "_result"}, 32'(result), 32'(m_result));
      check({tag, "_win"},    32'(win),    32'(m_phase == PH_WIN));
      check({tag, "_lose"},   32'(lose),   32'(m_phase == PH_LOSE));
   endtask

   task automatic model_clear();
      m_phase = PH_IDLE; m_data = 0; m_tries = 0; m_result = 0;
   endtask

   task automatic model_press(input bit inc, input bit sub, input int press_cyc);
      if (sub) begin
         if (m_phase == PH_IDLE) begin
            m_target = (press_cyc + LAT) % 10;
            m_phase  = PH_PLAY;
         end else if (m_phase == PH_PLAY) begin
            m_tries++;
            m_result = (m_data < m_target) ? 1 : (m_data > m_target) ? 2 : 3;
            if (m_data == m_target) m_phase = PH_WIN;
            else if (m_tries == MT) begin
               m_phase = PH_LOSE;
               m_data  = m_target;
            end
         end else begin
            model_clear();
         end
      end else if (inc && m_phase == PH_PLAY) begin
         m_data = (m_data + 1) % 10;
      end
   endtask

   // Caller is just past a rising edge.
   task automatic press_now(input bit inc, input bit sub, input string tag);
      int k;
      k = cyc;
      key_inc = inc; key_submit = sub;
      repeat (12) @(posedge CLK);
      #1; key_inc = 1'b0; key_submit = 1'b0;
      repeat (12) @(posedge CLK);
      model_press(inc, sub, k);
      check_all(tag);
   endtask

   task automatic press(input bit inc, input bit sub, input string tag);
      @(posedge CLK); #1;
      press_now(inc, sub, tag);
   endtask

   task automatic press_n(input int n, input string tag);
      for (int i = 0; i < n; i++) press(1'b1, 1'b0, tag);
   endtask

   task automatic glitch(input bit inc, input bit sub, input int len);
      @(posedge CLK); #1;
      key_inc = inc; key_submit = sub;
      repeat (len) @(posedge CLK);
      #1; key_inc = 1'b0; key_submit = 1'b0;
      repeat (15) @(posedge CLK);
   endtask

   // Submit timed so the latched target becomes tgt.
   task automatic start_with_target(input int tgt, input string tag);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge CLK); #1;
         if ((cyc + LAT) % 10 == tgt) found = 1'b1;
      end
      check({tag, "_align"}, 32'(found), 32'd1);
      press_now(1'b0, 1'b1, tag);
   endtask

   initial begin
      // Reset, then glitches shorter than the debounce window
      repeat (2) @(posedge CLK);
      #1; RST = 1'b0;
      check_all("reset");
      glitch(1'b1, 1'b0, 3);
      check_all("glitch_inc");
      glitch(1'b0, 1'b1, 3);
      press(1'b1, 1'b0, "glitch_sub_still_idle");

      // Start with target 7, wrap the guess
      start_with_target(7, "start7");
      press_n(12, "wrap");
      check("wrap_end", 32'(data), 32'd2);

      // Grade to WIN
      press(1'b0, 1'b1, "sub_low");
      press_n(6, "to8");
      press(1'b0, 1'b1, "sub_high");
      press_n(9, "to7");
      press(1'b0, 1'b1, "sub_hit");
      check("win_flag", 32'(win), 32'd1);
      press(1'b0, 1'b1, "win_to_idle");

      // LOSE reveals target
      start_with_target(4, "start4");
      for (int i = 0; i < 3; i++) press(1'b0, 1'b1, "lose_sub");
      check("lose_reveal", 32'(data), 32'd4);
      press_n(2, "lose_inc_ignored");
      press(1'b0, 1'b1, "lose_to_idle");

      // Simultaneous presses
      start_with_target(5, "start5");
      press_n(3, "to3");
      press(1'b1, 1'b1, "both");
      check("both_data", 32'(data), 32'd3);

      // Reset mid-game, then confirm the random counter restarted
      press_n(3, "to6");
      press(1'b0, 1'b1, "sub6");
      @(posedge CLK); #1; RST = 1'b1;
      @(posedge CLK); #1; RST = 1'b0;
      model_clear();
      check_all("mid_reset");
      start_with_target(3, "start3");
      for (int i = 0; i < 3; i++) press(1'b0, 1'b1, "lose3");

      // Random play
      for (int n = 0; n < 60; n++) begin
         int kind;
         repeat ($urandom_range(0, 9)) @(posedge CLK);
         kind = int'($urandom_range(0, 7));
         if (kind == 0) begin
            glitch(1'b1, 1'b1, int'($urandom_range(1, DB - 1)));
            check_all("rnd_glitch");
         end else if (kind <= 3) begin
            press(1'b1, 1'b0, "rnd_inc");
         end else if (kind <= 6) begin
            press(1'b0, 1'b1, "rnd_sub");
         end else begin
            press(1'b1, 1'b1, "rnd_both");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
